// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter: digit width,
// blank code and FSM state encoding.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 4'hF;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // 10^n saturating at all-ones so oversized DIGITS never wraps the range check
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        if (n > 19) begin
            r = '1;
        end else begin
            for (int i = 0; i < n; i++) begin
                r = r * 64'd10;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/bcd_converter.sv
// Sequential double-dabble converter, one input bit per clock.
// Optional macro BCD_LEADING_BLANK_EN replaces leading zero digits with the blank code.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready; accept bin_in when in_valid
// ST_SHIFT | add-3 adjust then shift one bit per cycle, WIDTH cycles
// ST_DONE  | publish scratch to bcd_out, out_valid pulses next cycle
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        bin_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [4*DIGITS-1:0]     bcd_out,
    output logic                    out_valid
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

    generate
        if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
            $error("bcd_converter: WIDTH must be in 4..32");
        end
        if (pow10(DIGITS) <= MAX_BIN) begin : g_bad_digits
            $error("bcd_converter: DIGITS too small for WIDTH");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               out_valid_q, out_valid_d;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   final_bcd;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .din  (scratch_q[g*DIGIT_W +: DIGIT_W]),
                .dout (adj[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

`ifdef BCD_LEADING_BLANK_EN
    logic lead_seen;

    // Walk from the top digit down; digit 0 is never blanked so zero shows as "0"
    always_comb begin
        lead_seen = 1'b0;
        final_bcd = scratch_q;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (scratch_q[d*DIGIT_W +: DIGIT_W] != '0) begin
                lead_seen = 1'b1;
            end
            if (!lead_seen) begin
                final_bcd[d*DIGIT_W +: DIGIT_W] = BLANK_DIGIT;
            end
        end
    end
`else
    assign final_bcd = scratch_q;
`endif

    always_comb begin
        state_d     = state_q;
        scratch_d   = scratch_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(WIDTH);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {scratch_d, shift_d} = {adj, shift_q} << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d       = final_bcd;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            scratch_q   <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            scratch_q   <= scratch_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign bcd_out   = bcd_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter (WIDTH=16, DIGITS=5); the driver queues
// expected results on acceptance, a monitor checks every out_valid pulse.
module tb_bcd_converter;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int LAT    = WIDTH + 1;

    logic                clk;
    logic                rst;
    logic [WIDTH-1:0]    bin_in;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd_out;
    logic                out_valid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;

    logic [4*DIGITS-1:0] exp_q[$];
    int                  acc_q[$];

    bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_in    (bin_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4*DIGITS-1:0] bcd_ref(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned x;
        bit seen;
        x = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef BCD_LEADING_BLANK_EN
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (r[i*4 +: 4] != 4'h0) seen = 1'b1;
            if (!seen) r[i*4 +: 4] = 4'hF;
        end
`else
        seen = 1'b0;
`endif
        return r;
    endfunction

    // Monitor: pop and compare on every out_valid pulse
    always begin
        logic [4*DIGITS-1:0] e;
        int a;
        @(negedge clk);
        #1;
        if (!rst && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out_valid got=%h expected=none", bcd_out);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                if (bcd_out !== e) begin
                    failures++;
                    $display("FAIL bcd_out got=%h expected=%h", bcd_out, e);
                end
                checks++;
                if (cyc - a != LAT) begin
                    failures++;
                    $display("FAIL latency got=%0d expected=%0d", cyc - a, LAT);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] v, input logic [4*DIGITS-1:0] e, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        bin_in   = v;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=busy expected=ready");
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            acc_q.push_back(cyc + 1);
            last_acc = cyc + 1;
            @(posedge clk);
            if (!hold) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2;
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d expected=0", exp_q.size());
        end
    endtask

    initial begin
        int a1;
        int busy_bad;
        logic [WIDTH-1:0] v;

        rst      = 1'b1;
        bin_in   = '0;
        in_valid = 1'b0;
        #12;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_bcd_out", 32'(bcd_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef BCD_LEADING_BLANK_EN
        send(16'd0,     20'hFFFF0, 1'b0);
        send(16'd255,   20'hFF255, 1'b0);
`else
        send(16'd0,     20'h00000, 1'b0);
        send(16'd255,   20'h00255, 1'b0);
`endif
        send(16'd65535, 20'h65535, 1'b0);
        wait_idle();

        // in_valid held high: back-to-back acceptances WIDTH+2 apart
`ifdef BCD_LEADING_BLANK_EN
        send(16'd10, 20'hFFF10, 1'b1);
        a1 = last_acc;
        send(16'd99, 20'hFFF99, 1'b0);
`else
        send(16'd10, 20'h00010, 1'b1);
        a1 = last_acc;
        send(16'd99, 20'h00099, 1'b0);
`endif
        check("accept_gap", 32'(last_acc - a1), 32'd18);
        wait_idle();

        // reset in the middle of converting 1234
        send(16'd1234, 20'h01234, 1'b0);
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        acc_q.delete();
        check("midrst_bcd_out", 32'(bcd_out), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_bcd_out", 32'(bcd_out), 32'd0);
`ifdef BCD_LEADING_BLANK_EN
        send(16'd42, 20'hFFF42, 1'b0);
`else
        send(16'd42, 20'h00042, 1'b0);
`endif
        wait_idle();

        // input changes and in_valid pulses while busy must be ignored
`ifdef BCD_LEADING_BLANK_EN
        send(16'd500, 20'hFF500, 1'b0);
`else
        send(16'd500, 20'h00500, 1'b0);
`endif
        busy_bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0) busy_bad++;
            if (i >= 2 && i <= 8) begin
                bin_in   = 16'd777;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        check("busy_in_ready_low", 32'(busy_bad), 32'd0);
        wait_idle();
        repeat (25) @(negedge clk);
        check("no_extra_conversion", 32'(exp_q.size()), 32'd0);
        check("hold_bcd_out", 32'(bcd_out), 32'(bcd_ref(500)));

        // random sweep against the decimal reference model
        for (int i = 0; i < 1000; i++) begin
            v = 16'($urandom_range(0, 65535));
            send(v, bcd_ref(32'(v)), 1'b0);
        end
        wait_idle();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
